// File: rtl/wb_rr_arbiter.sv
// Purpose : round-robin arbiter sharing one Wishbone slave port among NUM_MASTERS masters, with a stall watchdog.
// Latency : grant one cycle after a request is seen in IDLE; request and response paths are combinational once granted.
// Backpress: a grant is held for the whole s_cyc; other masters must hold cyc/stb until the bus is released.
//
// Ports:
//   clk_i, rstn_i                  clock, asynchronous active-low reset
//   s_cyc/s_stb/s_we/s_adr/s_wdat/s_sel   per-master requests (flattened, master i in slice i)
//   s_ack/s_err                    per-master terminations; s_rdat is broadcast read data
//   m_cyc/m_stb/m_we/m_adr/m_wdat/m_sel   request to the shared slave; m_ack/m_err/m_rdat its response
//   grant_o                        registered one-hot grant, zero when idle
//   timeout_o                      one-cycle pulse when the watchdog terminates an access
module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                                  clk_i,
    input  logic                                  rstn_i,
    input  logic [NUM_MASTERS-1:0]                s_cyc,
    input  logic [NUM_MASTERS-1:0]                s_stb,
    input  logic [NUM_MASTERS-1:0]                s_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     s_adr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     s_wdat,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   s_sel,
    output logic [NUM_MASTERS-1:0]                s_ack,
    output logic [NUM_MASTERS-1:0]                s_err,
    output logic [DATA_WIDTH-1:0]                 s_rdat,
    output logic                                  m_cyc,
    output logic                                  m_stb,
    output logic                                  m_we,
    output logic [ADDR_WIDTH-1:0]                 m_adr,
    output logic [DATA_WIDTH-1:0]                 m_wdat,
    output logic [DATA_WIDTH/8-1:0]               m_sel,
    input  logic                                  m_ack,
    input  logic                                  m_err,
    input  logic [DATA_WIDTH-1:0]                 m_rdat,
    output logic [NUM_MASTERS-1:0]                grant_o,
    output logic                                  timeout_o
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          last_q, last_d;     // last granted master; also the current grant index while BUSY
    logic [CW-1:0]          wd_cnt_q, wd_cnt_d;

    logic [NUM_MASTERS-1:0] req;
    logic                   pick_vld;
    logic [IW-1:0]          pick_idx;
    logic [IW-1:0]          cand_idx;
    logic                   busy;
    logic                   g_cyc;
    logic                   g_stb;
    logic                   resp;
    logic                   wd_fire;

    assign req    = s_cyc & s_stb;
    assign busy   = (state_q == BUSY);
    assign g_cyc  = busy & s_cyc[last_q];
    assign g_stb  = busy & s_stb[last_q];
    assign resp   = m_ack | m_err;
    // A slave response in the expiry cycle takes precedence over the watchdog.
    assign wd_fire = g_stb & ~resp & (wd_cnt_q == CW'(TIMEOUT));

    // Rotating-priority search: first requester above the last grant, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = last_q;
        cand_idx = last_q;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand_idx = IW'((int'(last_q) + k) % NUM_MASTERS);
            if (!pick_vld && req[cand_idx]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    last_d            = pick_idx;
                    state_d           = BUSY;
                end
            end
            BUSY: begin
                // Release only; re-arbitration waits for the following IDLE cycle.
                if (!g_cyc) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        if (!g_stb || resp || wd_fire) begin
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= IW'(NUM_MASTERS - 1);
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    // Slave-side mux and response routing; everything is zero without a grant.
    always_comb begin
        m_cyc  = 1'b0;
        m_stb  = 1'b0;
        m_we   = 1'b0;
        m_adr  = '0;
        m_wdat = '0;
        m_sel  = '0;
        s_ack  = '0;
        s_err  = '0;
        if (busy) begin
            m_cyc          = s_cyc[last_q];
            m_stb          = s_stb[last_q];
            m_we           = s_we[last_q];
            m_adr          = s_adr[int'(last_q)*ADDR_WIDTH +: ADDR_WIDTH];
            m_wdat         = s_wdat[int'(last_q)*DATA_WIDTH +: DATA_WIDTH];
            m_sel          = s_sel[int'(last_q)*SW +: SW];
            s_ack[last_q]  = m_ack;
            s_err[last_q]  = m_err | wd_fire;
        end
    end

    assign s_rdat    = m_rdat;
    assign grant_o   = grant_q;
    assign timeout_o = wd_fire;

endmodule
